// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants for the PS/2 keystroke tracker: protocol byte values,
// the list of codes that carry no key information, FSM encodings and the
// digit slots used by the LED display map.
package ps2_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_E1 = 8'hE1;

  // Keyboard status/ack codes dropped when no prefix is pending.
  localparam int               N_IGNORED     = 7;
  localparam logic [8*N_IGNORED-1:0] IGNORED_CODES =
    {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, PS2_E1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } kb_state_t;

  localparam int DIG_CODE_LO = 0;
  localparam int DIG_CODE_HI = 1;
  localparam int DIG_EXT     = 2;
  localparam int DIG_GAP     = 3;
  localparam int DIG_CNT0    = 4;

  function automatic logic is_ignored(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_IGNORED; i++) begin
      if (b == IGNORED_CODES[8*i +: 8]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// FIFO-side handshake between ps2_keyboard (master) and the tracker (slave).
interface ps2_key_tracker_if;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       kb_nextdata_n;
  logic       kb_clrn;

  modport master (
    output kb_data, kb_ready, kb_overflow,
    input  kb_nextdata_n, kb_clrn
  );

  modport slave (
    input  kb_data, kb_ready, kb_overflow,
    output kb_nextdata_n, kb_clrn
  );
endinterface

// File: rtl/ps2_key_tracker_bcd_counter.sv
// Wrapping BCD counter with increment enable and a leading-zero mask.
// Mask bit d is set when digit d and every digit above it are zero; the
// least significant digit is never masked so the value 0 still shows.
module bcd_counter #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                i_inc,
  output logic [4*DIGITS-1:0] o_count,
  output logic [DIGITS-1:0]   o_lz
);

  logic [4*DIGITS-1:0] r_count;
  logic [4*DIGITS-1:0] w_count_nxt;

  // Ripple the carry through the decades; carry out of the top is dropped,
  // so all-nines rolls over to zero.
  always_comb begin : p_inc
    logic w_carry;
    w_count_nxt = r_count;
    w_carry     = i_inc;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_carry) begin
        if (r_count[4*d +: 4] == 4'd9) begin
          w_count_nxt[4*d +: 4] = 4'd0;
        end else begin
          w_count_nxt[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_count <= '0;
    else       r_count <= w_count_nxt;
  end

  // Leading-zero mask, scanned from the most significant digit down.
  always_comb begin : p_lz
    logic w_nz;
    w_nz = 1'b0;
    o_lz = '0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      w_nz    = w_nz | (r_count[4*d +: 4] != 4'd0);
      o_lz[d] = ~w_nz;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keystroke tracker: drains the keyboard FIFO, decodes make/break with
// E0 extension, suppresses typematic repeats, counts presses in BCD and
// drives a blank-masked hex digit bus for the LED driver.
module ps2_key_tracker #(
  parameter int NUM_DIGITS = 8,
  parameter int CNT_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    clrn,
  ps2_key_tracker_if.slave        kb,
  output logic [7:0]              key_code,
  output logic                    key_ext,
  output logic                    key_held,
  output logic                    key_down,
  output logic                    key_up,
  output logic                    ovf_flag,
  output logic [4*NUM_DIGITS-1:0] disp_data,
  output logic [NUM_DIGITS-1:0]   disp_blank
);
  import ps2_pkg::*;

  kb_state_t r_state, w_state_nxt;

  logic        r_nextdata_n;
  logic        r_kb_clrn;
  logic [8:0]  r_held_id;
  logic        r_held;
  logic [7:0]  r_code;
  logic        r_ext;
  logic        r_seen;
  logic        r_down;
  logic        r_up;
  logic        r_ovf;

  logic        w_pop;
  logic        w_make;
  logic        w_brk;
  logic        w_ext;
  logic [8:0]  w_id;
  logic        w_new_press;
  logic        w_release;

  logic [4*CNT_DIGITS-1:0] w_count;
  logic [CNT_DIGITS-1:0]   w_lz;

  // The registered strobe blocks a second pop in the cycle right after one,
  // which gives the FIFO time to advance its head.
  assign w_pop = kb.kb_ready & ~kb.kb_overflow & r_nextdata_n;

  // Prefix-tracking FSM: next state and decoded make/break event.
  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    if (w_pop) begin
      case (r_state)
        ST_IDLE: begin
          if (kb.kb_data == PS2_E0)      w_state_nxt = ST_E0;
          else if (kb.kb_data == PS2_F0) w_state_nxt = ST_F0;
          else if (!is_ignored(kb.kb_data)) w_make = 1'b1;
        end
        ST_E0: begin
          if (kb.kb_data == PS2_F0) begin
            w_state_nxt = ST_E0F0;
          end else if (kb.kb_data != PS2_E0) begin
            w_make      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_F0: begin
          w_brk       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_E0F0: begin
          w_brk       = 1'b1;
          w_ext       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    // Overflow discards any partial sequence.
    if (kb.kb_overflow) w_state_nxt = ST_IDLE;
  end

  assign w_id        = {w_ext, kb.kb_data};
  assign w_new_press = w_make & ~(r_held & (w_id == r_held_id));
  assign w_release   = w_brk & r_held & (w_id == r_held_id);

  // FSM state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Handshake strobes, key status, pulses and sticky overflow.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_nextdata_n <= 1'b1;
      r_kb_clrn    <= 1'b0;
      r_held_id    <= '0;
      r_held       <= 1'b0;
      r_code       <= '0;
      r_ext        <= 1'b0;
      r_seen       <= 1'b0;
      r_down       <= 1'b0;
      r_up         <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_nextdata_n <= ~w_pop;
      r_kb_clrn    <= ~kb.kb_overflow;
      r_down       <= w_new_press;
      r_up         <= w_release;
      if (w_new_press) begin
        r_held_id <= w_id;
        r_held    <= 1'b1;
        r_code    <= kb.kb_data;
        r_ext     <= w_ext;
        r_seen    <= 1'b1;
      end else if (w_release) begin
        r_held <= 1'b0;
      end
      if (kb.kb_overflow) begin
        r_held <= 1'b0;
        r_ovf  <= 1'b1;
      end
    end
  end

  bcd_counter #(
    .DIGITS (CNT_DIGITS)
  ) u_cnt (
    .clk     (clk),
    .clrn    (clrn),
    .i_inc   (w_new_press),
    .o_count (w_count),
    .o_lz    (w_lz)
  );

  // Display map, decoded purely from registered state so it moves in the
  // same cycle as the key outputs.
  always_comb begin
    disp_data  = '0;
    disp_blank = '1;
    disp_data[4*DIG_CODE_LO +: 4] = r_code[3:0];
    disp_data[4*DIG_CODE_HI +: 4] = r_code[7:4];
    disp_blank[DIG_CODE_LO]       = ~r_seen;
    disp_blank[DIG_CODE_HI]       = ~r_seen;
    disp_data[4*DIG_EXT +: 4]     = r_ext ? 4'hE : 4'h0;
    disp_blank[DIG_EXT]           = ~r_ext;
    disp_blank[DIG_GAP]           = 1'b1;
    for (int d = 0; d < CNT_DIGITS; d++) begin
      disp_data[4*(DIG_CNT0+d) +: 4] = w_count[4*d +: 4];
      disp_blank[DIG_CNT0+d]         = w_lz[d];
    end
  end

  assign kb.kb_nextdata_n = r_nextdata_n;
  assign kb.kb_clrn       = r_kb_clrn;
  assign key_code         = r_code;
  assign key_ext          = r_ext;
  assign key_held         = r_held;
  assign key_down         = r_down;
  assign key_up           = r_up;
  assign ovf_flag         = r_ovf;

endmodule
